// File: rtl/nasti_lite_initiator.sv
// Single-outstanding AXI4-Lite initiator: turns a simple request/response port into
// AXI-Lite reads and writes, with a response timeout and draining of late responses.
module nasti_lite_initiator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] ar_addr,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    input  logic [DATA_WIDTH-1:0] r_data,
    input  logic [1:0]            r_resp,
    input  logic                  r_valid,
    output logic                  r_ready,
    output logic [ADDR_WIDTH-1:0] aw_addr,
    output logic                  aw_valid,
    input  logic                  aw_ready,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    input  logic [1:0]            b_resp,
    input  logic                  b_valid,
    output logic                  b_ready
);

    // Every channel: a transfer happens on a rising clk edge where valid and ready are
    // both high; a valid, once raised, holds with stable payload until that transfer
    // (the only exception is the timeout abandoning a hung slave).

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 2) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WREQ  = 3'd1,
        WRESP = 3'd2,
        RREQ  = 3'd3,
        RDATA = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  aw_valid_q, aw_valid_d;
    logic                  w_valid_q, w_valid_d;
    logic                  ar_valid_q, ar_valid_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  stale_b_q, stale_b_d;
    logic                  stale_r_q, stale_r_d;
    logic                  aw_left, w_left, timeout_hit, to_fire, req_ready_c;

    assign req_ready_c = (state_q == IDLE) & ~stale_b_q & ~stale_r_q;
    assign aw_left     = aw_valid_q & ~aw_ready;
    assign w_left      = w_valid_q & ~w_ready;
    assign timeout_hit = TO_EN && (cnt_q >= TO_LAST);

    assign req_ready   = req_ready_c;
    assign b_ready     = (state_q == WRESP) | stale_b_q;
    assign r_ready     = (state_q == RDATA) | stale_r_q;
    assign ar_addr     = addr_q;
    assign aw_addr     = addr_q;
    assign w_data      = wdata_q;
    assign ar_valid    = ar_valid_q;
    assign aw_valid    = aw_valid_q;
    assign w_valid     = w_valid_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            aw_valid_q    <= 1'b0;
            w_valid_q     <= 1'b0;
            ar_valid_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            stale_b_q     <= 1'b0;
            stale_r_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            aw_valid_q    <= aw_valid_d;
            w_valid_q     <= w_valid_d;
            ar_valid_q    <= ar_valid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            stale_b_q     <= stale_b_d;
            stale_r_q     <= stale_r_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        aw_valid_d    = aw_valid_q;
        w_valid_d     = w_valid_q;
        ar_valid_d    = ar_valid_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        stale_b_d     = stale_b_q;
        stale_r_d     = stale_r_q;
        to_fire       = 1'b0;

        // Late responses from abandoned transactions are swallowed here, never reported.
        if (stale_b_q && b_valid) stale_b_d = 1'b0;
        if (stale_r_q && r_valid) stale_r_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_c) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    if (req_write) begin
                        state_d    = WREQ;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = RREQ;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            WREQ: begin
                cnt_d = cnt_q + 1'b1;
                if (!aw_left && !w_left) begin
                    aw_valid_d = 1'b0;
                    w_valid_d  = 1'b0;
                    state_d    = WRESP;
                end else if (timeout_hit) begin
                    to_fire   = 1'b1;
                    // The slave may already hold half a write and answer with a B later.
                    stale_b_d = !aw_left || !w_left;
                end else begin
                    aw_valid_d = aw_left;
                    w_valid_d  = w_left;
                end
            end
            WRESP: begin
                cnt_d = cnt_q + 1'b1;
                if (b_valid) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = (b_resp != 2'b00);
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (timeout_hit) begin
                    to_fire   = 1'b1;
                    stale_b_d = 1'b1;
                end
            end
            RREQ: begin
                cnt_d = cnt_q + 1'b1;
                if (ar_ready) begin
                    ar_valid_d = 1'b0;
                    state_d    = RDATA;
                end else if (timeout_hit) begin
                    to_fire = 1'b1;
                end
            end
            RDATA: begin
                cnt_d = cnt_q + 1'b1;
                if (r_valid) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = r_data;
                    rsp_err_d     = (r_resp != 2'b00);
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (timeout_hit) begin
                    to_fire   = 1'b1;
                    stale_r_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (to_fire) begin
            aw_valid_d    = 1'b0;
            w_valid_d     = 1'b0;
            ar_valid_d    = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            state_d       = RESP;
        end
    end

endmodule
